// File: rtl/shift_add_multiplier16_if.sv
// Operand/product handshake bundle for shift_add_multiplier16.
// master: operand source + product consumer; slave: the multiplier.
interface shift_add_multiplier16_if #(
  parameter int unsigned WIDTH = 16
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] product;
  logic               busy;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, product, busy
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, product, busy
  );
endinterface

// File: rtl/shift_add_multiplier16.sv
// Sequential radix-2 shift-and-add unsigned multiplier, WIDTH x WIDTH -> 2*WIDTH.
// One WIDTH-bit adder with carry out; ACC:Q shift right by one each RUN cycle.
// Optional macro SHIFT_ADD_MUL_ZERO_SKIP_EN: zero operands bypass RUN and go
// straight to DONE with a zero product.
module shift_add_multiplier16 #(
  parameter int unsigned WIDTH = 16
) (
  input logic                     clk,
  input logic                     rst_n,
  shift_add_multiplier16_if.slave bus
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic [CntW-1:0]    count_q, count_d;
  logic [2*WIDTH-1:0] product_q, product_d;

  // Adder instance point: keep the carry out, the top sum bit lands in ACC.
  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   addend;
  logic               skip;

  assign addend = q_q[0] ? m_q : '0;
  assign sum    = {1'b0, acc_q} + {1'b0, addend};

`ifdef SHIFT_ADD_MUL_ZERO_SKIP_EN
  assign skip = (bus.a == '0) || (bus.b == '0);
`else
  assign skip = 1'b0;
`endif

  // Handshake outputs depend on state only.
  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = (state_q == StDone);
  assign bus.busy      = (state_q != StIdle);
  assign bus.product   = product_q;

  // Next-state and datapath update.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    q_d       = q_q;
    m_d       = m_q;
    count_d   = count_q;
    product_d = product_q;
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          if (skip) begin
            product_d = '0;
            state_d   = StDone;
          end else begin
            m_d     = bus.a;
            q_d     = bus.b;
            acc_d   = '0;
            count_d = '0;
            state_d = StRun;
          end
        end
      end
      StRun: begin
        acc_d   = sum[WIDTH:1];
        q_d     = {sum[0], q_q[WIDTH-1:1]};
        count_d = count_q + CntW'(1);
        if (count_q == CntW'(WIDTH - 1)) begin
          product_d = {sum[WIDTH:1], sum[0], q_q[WIDTH-1:1]};
          state_d   = StDone;
        end
      end
      StDone: begin
        if (bus.out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      acc_q     <= '0;
      q_q       <= '0;
      m_q       <= '0;
      count_q   <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      q_q       <= q_d;
      m_q       <= m_d;
      count_q   <= count_d;
      product_q <= product_d;
    end
  end

endmodule

// File: tb/tb_shift_add_multiplier16.sv
// Directed testbench for shift_add_multiplier16 (WIDTH=16).
module tb_shift_add_multiplier16;

  localparam int unsigned WIDTH = 16;

  logic clk;
  logic rst_n;
  int   err_cnt;
  int   chk_cnt;

  shift_add_multiplier16_if #(.WIDTH(WIDTH)) bus ();

  shift_add_multiplier16 #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock; sample/drive 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, ".in_ready"}, 32'(bus.in_ready), 32'd1);
    check_eq({tag, ".out_valid"}, 32'(bus.out_valid), 32'd0);
    check_eq({tag, ".busy"}, 32'(bus.busy), 32'd0);
    check_eq({tag, ".product"}, bus.product, 32'd0);
  endtask

  // Accept one operand pair, wait for the product, hold it for 'hold' cycles,
  // then hand it off. With 'spam' set, in_valid stays high (a=b=1) during RUN.
  task automatic run_mul(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic [31:0] exp, input int exp_lat, input int hold,
                         input bit spam);
    int  cyc;
    bit  rdy_bad;
    check_eq({tag, ".in_ready_pre"}, 32'(bus.in_ready), 32'd1);
    bus.a         = a;
    bus.b         = b;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    tick();
    bus.in_valid = spam;
    bus.a        = spam ? 16'd1 : 16'd0;
    bus.b        = spam ? 16'd1 : 16'd0;
    cyc     = 0;
    rdy_bad = 1'b0;
    while (!bus.out_valid && cyc < 40) begin
      if (bus.in_ready !== 1'b0 || bus.busy !== 1'b1) rdy_bad = 1'b1;
      tick();
      cyc++;
    end
    bus.in_valid = 1'b0;
    check_eq({tag, ".out_valid"}, 32'(bus.out_valid), 32'd1);
    check_eq({tag, ".latency"}, 32'(cyc), 32'(exp_lat));
    check_eq({tag, ".ready_in_run"}, 32'(rdy_bad), 32'd0);
    check_eq({tag, ".product"}, bus.product, exp);
    for (int h = 0; h < hold; h++) begin
      tick();
      check_eq({tag, ".hold_valid"}, 32'(bus.out_valid), 32'd1);
      check_eq({tag, ".hold_product"}, bus.product, exp);
      check_eq({tag, ".hold_in_ready"}, 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check_eq({tag, ".post_valid"}, 32'(bus.out_valid), 32'd0);
    check_eq({tag, ".post_in_ready"}, 32'(bus.in_ready), 32'd1);
    check_eq({tag, ".post_product"}, bus.product, exp);
  endtask

  initial begin
    int zero_lat;
    err_cnt       = 0;
    chk_cnt       = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    check_idle("reset");
    tick();
    check_idle("idle_after_reset");

    run_mul("mul_3x5", 16'd3, 16'd5, 32'h0000_000F, 16, 0, 1'b0);
    run_mul("mul_ffff", 16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 16, 0, 1'b0);
    run_mul("mul_1234", 16'h1234, 16'h5678, 32'h0626_0060, 16, 5, 1'b0);
    run_mul("mul_spam", 16'd7, 16'd9, 32'h0000_003F, 16, 0, 1'b1);
    run_mul("mul_after_spam", 16'h00FF, 16'h0100, 32'h0000_FF00, 16, 1, 1'b0);
    run_mul("mul_carry", 16'h8000, 16'h0002, 32'h0001_0000, 16, 0, 1'b0);

    // Reset in the middle of RUN aborts the operation.
    bus.a        = 16'hABCD;
    bus.b        = 16'h0002;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    check_eq("abort.busy_before", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_idle("abort");
    run_mul("mul_2x3", 16'd2, 16'd3, 32'h0000_0006, 16, 0, 1'b0);

`ifdef SHIFT_ADD_MUL_ZERO_SKIP_EN
    zero_lat = 0;
`else
    zero_lat = 16;
`endif
    run_mul("mul_zero", 16'd0, 16'h1234, 32'h0000_0000, zero_lat, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/shift_add_multiplier16.md
Name: shift_add_multiplier16

Overview:
- Sequential radix-2 shift-and-add unsigned multiplier, WIDTH x WIDTH -> 2*WIDTH.
- Contains one WIDTH-bit adder producing a WIDTH+1-bit sum. The adder is the instance point for the team's 16-bit prefix adders.
- Each cycle the block registers the adder's sum and carry, then shifts.
- Valid/ready handshake on both sides. Sits between operand source and the downstream product consumer.

Parameters:
- WIDTH, 16, operand width; legal range is WIDTH >= 2. Product width is 2*WIDTH.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  operands a/b valid
- in_ready  out  1  block can accept operands
- a  in  WIDTH  multiplicand (unsigned)
- b  in  WIDTH  multiplier (unsigned)
- out_valid  out  1  product valid
- out_ready  in  1  consumer accepts product
- product  out  2*WIDTH  a*b result
- busy  out  1  high in RUN or DONE

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-low (rst_n), sampled on the rising edge of clk.
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, product=0. Internal ACC, Q, M and count are all 0.
- Reset mid-operation: aborts the operation; the next cycle is IDLE with the values above. No partial product is ever presented.
- States: IDLE, RUN, DONE. Encoding is free.
- IDLE:
  - in_ready=1.
  - On in_valid: M<=a, Q<=b, ACC<=0, count<=0, go to RUN.
  - in_ready is a pure function of state and does not depend on in_valid.
- RUN:
  - in_ready=0. in_valid is ignored; operands are not captured.
  - Each cycle: sum[WIDTH:0] = ACC + (Q[0] ? M : 0).
  - Then ACC<=sum[WIDTH:1], Q<={sum[0],Q[WIDTH-1:1]}, count<=count+1.
  - When count==WIDTH-1, after this cycle's update go to DONE and load product<={ACC_next,Q_next}.
  - The carry out of the adder must be retained (WIDTH+1-bit sum); truncation is a bug.
- DONE:
  - out_valid=1; product is held stable while out_valid=1 and out_ready=0.
  - On out_ready: go to IDLE, out_valid deasserts next cycle.
  - No new operands are accepted in the same cycle as the handoff. Throughput is one product per WIDTH+2 cycles minimum.
- Latency: handshake at edge E0 -> RUN iterations at edges E1..E16 (WIDTH=16) -> out_valid high from just after E16.
- product register: retains its last value after handoff until the next completion or reset.
- count width: clog2(WIDTH+1).
- Arithmetic is unsigned only. Maximum result is (2^WIDTH-1)^2, which fits in 2*WIDTH with no overflow.

Optional Feature:
- Macro: SHIFT_ADD_MUL_ZERO_SKIP_EN
- Defined: in IDLE, if in_valid and (a==0 or b==0), skip RUN. Go directly to DONE with product<=0, giving out_valid one cycle after acceptance. Nonzero operands behave exactly as the baseline.
- Undefined: all operands take the full WIDTH-cycle RUN. A zero product appears after the normal latency.

Test Plan:
- Reset, then a=3, b=5, in_valid=1 for one cycle, out_ready=1 -> out_valid rises 16 cycles after accept with product=0x0000000F. in_ready=0 throughout RUN/DONE, and in_ready=1 one cycle after handoff.
- a=0xFFFF, b=0xFFFF -> product=0xFFFE0001. This exercises the adder carry-out on every iteration.
- a=0x1234, b=0x5678, out_ready held 0 for 5 cycles after out_valid -> product=0x06260060 held stable with out_valid=1. Handoff occurs on the cycle out_ready=1.
- During RUN of 7*9, drive in_valid with a=1, b=1 every cycle -> ignored; product=0x0000003F. The next accepted operands after return to IDLE produce their own correct product.
- Start a=0xABCD, b=0x0002, assert rst_n=0 for one cycle at RUN iteration 8 -> next cycle state IDLE, out_valid=0, product=0. A subsequent 2*3 gives product=6.
- With SHIFT_ADD_MUL_ZERO_SKIP_EN: a=0, b=0x1234 -> out_valid one cycle after accept, product=0. Without the macro: out_valid after 16 RUN cycles, product=0.
